lm_sm_sequencer: RTL and testbench

Register-read-stage micro-sequencer that expands one LM/SM instruction into one register transfer per cycle. It drives the 24-bit `LM_signals` bundle captured by the RR/EX pipeline register and stalls the upstream PC, IF/ID and ID/RR stages until the last transfer issues. Transfers are walked lowest-register-first from the instruction's 8-bit register list, with a per-transfer word address of base plus transfer count.

---
 rtl/lm_sm_sequencer_pkg.sv | 26 ++
 rtl/lm_sm_sequencer_priority_encoder_8.sv | 17 +
 rtl/lm_sm_sequencer.sv | 126 ++++++++++++
 tb/tb_lm_sm_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/lm_sm_sequencer_pkg.sv
// Shared types and LM_signals bit positions for the LM/SM register-read micro-sequencer.
package lm_sm_sequencer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int LM_SIGNALS_W = 24;
  localparam int ONE_SEL      = 0;
  localparam int LM_DEST_SEL  = 1;
  localparam int LM_WR_SEL    = 2;
  localparam int LM_REG_WRITE = 3;
  localparam int FWD_BIT      = 4;
  localparam int PE_OUT_LSB   = 5;
  localparam int PE_OUT_MSB   = 7;
  localparam int ALU_IN_LSB   = 8;
  localparam int ALU_IN_MSB   = 23;
  localparam int ALU_IN_W     = ALU_IN_MSB - ALU_IN_LSB + 1;

  // True when at least two bits are set: clearing the lowest one leaves something behind.
  function automatic logic multi_bit(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

endpackage

// File: rtl/lm_sm_sequencer_priority_encoder_8.sv
// Lowest-set-bit encoder for an 8-bit register list.
module priority_encoder_8 (
  input  logic [7:0] vec,
  output logic [2:0] idx,
  output logic       found
);

  // Scan from the top so the last hit written is the lowest set bit.
  always_comb begin
    idx   = '0;
    found = |vec;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/lm_sm_sequencer.sv
// Expands one LM/SM instruction into one register transfer per cycle, lowest register first,
// stalling the upstream stages until the last transfer issues.
//
//   state | meaning
//   IDLE  | waiting for start; the first transfer issues straight from the inputs
//   RUN   | walking the latched list; one transfer per un-held cycle
module lm_sm_sequencer
  import lm_sm_sequencer_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    start,
  input  logic                    is_lm,
  input  logic [7:0]              reg_list,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic                    hold,
  input  logic                    flush,
  output logic [LM_SIGNALS_W-1:0] LM_signals,
  output logic                    seq_valid,
  output logic                    stall_upstream,
  output logic                    busy,
  output logic                    done
);

  state_t              state_q, state_d;
  logic [7:0]          remaining_q, remaining_d;
  logic [2:0]          count_q, count_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                lm_q, lm_d;

  logic                run;
  logic [7:0]          list;
  logic [7:0]          list_next;
  logic                multi;
  logic                active;
  logic                issue;
  logic                lm_cur;
  logic [2:0]          cnt_cur;
  logic [ADDR_W-1:0]   addr_cur;
  logic [2:0]          pe_idx;
  logic                pe_found;

  assign run       = (state_q == RUN);
  assign list      = run ? remaining_q : reg_list;
  assign list_next = list & (list - 8'd1);
  assign multi     = multi_bit(list);

  priority_encoder_8 u_pe (
    .vec   (list),
    .idx   (pe_idx),
    .found (pe_found)
  );

  always_comb begin
    active   = clear && !flush;
    issue    = active && pe_found && (run || start);
    lm_cur   = run ? lm_q : is_lm;
    cnt_cur  = run ? count_q : 3'd0;
    addr_cur = run ? (base_q + ADDR_W'(count_q)) : base_addr;

    LM_signals = '0;
    if (issue) begin
      LM_signals[ONE_SEL]                   = (cnt_cur != 3'd0);
      LM_signals[LM_DEST_SEL]               = lm_cur;
      LM_signals[LM_WR_SEL]                 = lm_cur;
      LM_signals[LM_REG_WRITE]              = lm_cur;
      LM_signals[FWD_BIT]                   = run;
      LM_signals[PE_OUT_MSB:PE_OUT_LSB]     = pe_idx;
      LM_signals[ALU_IN_MSB:ALU_IN_LSB]     = ALU_IN_W'(addr_cur);
    end

    seq_valid      = issue;
    stall_upstream = issue && multi;
    // An empty list still completes the instruction so the pipeline can retire it.
    done           = active && ((issue && !multi) || (!run && start && !pe_found));
    busy           = active && run;
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    count_d     = count_q;
    base_d      = base_q;
    lm_d        = lm_q;

    if (flush) begin
      state_d     = IDLE;
      remaining_d = '0;
      count_d     = '0;
    end else if (!hold) begin
      if (run) begin
        remaining_d = list_next;
        count_d     = count_q + 3'd1;
        if (!multi) begin
          state_d = IDLE;
          count_d = '0;
        end
      end else if (start && pe_found && multi) begin
        state_d     = RUN;
        remaining_d = list_next;
        count_d     = 3'd1;
        base_d      = base_addr;
        lm_d        = is_lm;
      end
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      count_q     <= '0;
      base_q      <= '0;
      lm_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
      base_q      <= base_d;
      lm_q        <= lm_d;
    end
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Scoreboard bench for lm_sm_sequencer: stimulus queues expected transfers, a negedge monitor checks them.
module tb_lm_sm_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        is_lm = 1'b0;
  logic [7:0]  reg_list = '0;
  logic [15:0] base_addr = '0;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic [23:0] LM_signals;
  logic        seq_valid;
  logic        stall_upstream;
  logic        busy;
  logic        done;

  lm_sm_sequencer #(.ADDR_W(16)) dut (
    .clock          (clock),
    .clear          (clear),
    .start          (start),
    .is_lm          (is_lm),
    .reg_list       (reg_list),
    .base_addr      (base_addr),
    .hold           (hold),
    .flush          (flush),
    .LM_signals     (LM_signals),
    .seq_valid      (seq_valid),
    .stall_upstream (stall_upstream),
    .busy           (busy),
    .done           (done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [23:0] sig;
    logic        valid;
    logic        stall;
    logic        dn;
    logic        bsy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [23:0] mk_sig(input logic [2:0] pe, input logic [15:0] alu,
                                         input logic one, input logic lm, input logic fwd);
    return {alu, pe, fwd, lm, lm, lm, one};
  endfunction

  task automatic push_exp(input logic [23:0] sig, input logic v, input logic s,
                          input logic d, input logic b);
    exp_t e;
    e = '{sig: sig, valid: v, stall: s, dn: d, bsy: b};
    exp_q.push_back(e);
  endtask

  // Reference walk of a list: transfer k goes to the k-th set bit at base+k.
  // Transfer number rep_k is expected (1+rep_n) times to model a hold on it.
  task automatic push_seq(input logic lm, input logic [7:0] lst, input logic [15:0] base,
                          input int rep_k, input int rep_n);
    int k;
    logic more;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (lst[i]) begin
        more = 1'b0;
        for (int j = i + 1; j < 8; j++) if (lst[j]) more = 1'b1;
        for (int r = 0; r <= ((k == rep_k) ? rep_n : 0); r++)
          push_exp(mk_sig(3'(i), base + 16'(k), k != 0, lm, k != 0), 1'b1, more, !more, k != 0);
        k++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic run_seq(input logic lm, input logic [7:0] lst, input logic [15:0] base,
                         input logic keep_start);
    push_seq(lm, lst, base, -1, 0);
    is_lm     = lm;
    reg_list  = lst;
    base_addr = base;
    start     = 1'b1;
    for (int c = 0; c < $countones(lst); c++) begin
      tick();
      if (!keep_start) start = 1'b0;
    end
    start = 1'b0;
  endtask

  always @(negedge clock) begin
    if (seq_valid || done || stall_upstream) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output sig=%h valid=%b stall=%b done=%b busy=%b",
                 LM_signals, seq_valid, stall_upstream, done, busy);
      end else begin
        mon_e = exp_q.pop_front();
        if ({LM_signals, seq_valid, stall_upstream, done, busy} !== mon_e) begin
          n_fail++;
          $display("FAIL transfer actual sig=%h v=%b s=%b d=%b b=%b required sig=%h v=%b s=%b d=%b b=%b",
                   LM_signals, seq_valid, stall_upstream, done, busy,
                   mon_e.sig, mon_e.valid, mon_e.stall, mon_e.dn, mon_e.bsy);
        end
      end
    end
  end

  initial begin
    // Reset held with an active-looking instruction on the inputs.
    start = 1'b1; is_lm = 1'b1; reg_list = 8'hFF; base_addr = 16'h1234;
    #12;
    check("reset_outputs", {LM_signals, seq_valid, stall_upstream, done, busy}, '0);
    start = 1'b0;
    tick();
    clear = 1'b1;
    tick();

    run_seq(1'b1, 8'b0000_0100, 16'h0040, 1'b0);
    run_seq(1'b0, 8'b1000_0011, 16'h0100, 1'b1);
    run_seq(1'b1, 8'hFF, 16'hFFFE, 1'b0);

    // Hold during the second transfer for three cycles.
    push_seq(1'b1, 8'h0F, 16'h0200, 1, 3);
    is_lm = 1'b1; reg_list = 8'h0F; base_addr = 16'h0200; start = 1'b1;
    tick();
    start = 1'b0;
    hold  = 1'b1;
    repeat (3) tick();
    hold = 1'b0;
    repeat (3) tick();

    // Flush on the second transfer, then a fresh instruction right after.
    push_exp(mk_sig(3'd4, 16'h0300, 1'b0, 1'b0, 1'b0), 1'b1, 1'b1, 1'b0, 1'b0);
    is_lm = 1'b0; reg_list = 8'hF0; base_addr = 16'h0300; start = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b1;
    #2;
    check("flush_outputs", {LM_signals, seq_valid, stall_upstream, done, busy}, '0);
    tick();
    flush = 1'b0;
    #1;
    check("flush_idle_busy", {27'd0, busy}, '0);
    run_seq(1'b1, 8'h01, 16'h0500, 1'b0);

    // Asynchronous reset mid-sequence.
    push_seq(1'b1, 8'h03, 16'h0600, -1, 0);
    exp_q[1].stall = 1'b1;
    exp_q[1].dn    = 1'b0;
    is_lm = 1'b1; reg_list = 8'h0F; base_addr = 16'h0600; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("run_before_clear", {27'd0, busy}, 28'd1);
    clear = 1'b0;
    start = 1'b1; reg_list = 8'hFF;
    #1;
    check("clear_outputs", {LM_signals, seq_valid, stall_upstream, done, busy}, '0);
    start = 1'b0;
    tick();
    clear = 1'b1;
    #1;
    check("after_clear_busy", {27'd0, busy}, '0);
    tick();

    // Empty list: completes without a transfer or a stall.
    push_exp(24'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    is_lm = 1'b1; reg_list = 8'h00; base_addr = 16'h0700; start = 1'b1;
    tick();
    start = 1'b0;
    #2;
    check("empty_no_busy", {27'd0, busy}, '0);
    repeat (3) tick();

    check("scoreboard_drained", 28'(exp_q.size()), 28'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
